multicycle_control_fsm: RTL
===========================

# multicycle_control_fsm

Main control unit for the multi-cycle RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath control input: PCwrite, Adrsrc, Memwrite, IRwrite, ALUsrcA/B, Resultsrc, immsrc, Regwrite and ALUcontrol. It consumes the latched instruction and the ALU zero flag from the datapath. It also provides a retire pulse and counter, plus an illegal-opcode flag, for verification.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- instr  in  32  latched instruction (IR output of datapath)
- zero1  in  1  ALU zero flag, combinational from current ALU operation
- PCwrite, Adrsrc, Memwrite, IRwrite, Regwrite  out  1 each  datapath strobes/selects
- ALUsrcA, ALUsrcB, Resultsrc, immsrc  out  2 each  datapath mux selects
- ALUcontrol  out  4  ALU operation
- state  out  4  current FSM state (debug)
- retire  out  1  one-cycle pulse on instruction completion
- illegal  out  1  one-cycle pulse on unsupported opcode/funct3 in DECODE
- instret  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

## Operation
- Mux encodings:
  - ALUsrcA: 00 PC, 01 oldPC, 10 A.
  - ALUsrcB: 00 B/WD, 01 immExt, 10 constant 4.
  - Resultsrc: 00 ALUout, 01 data, 10 ALUresult.
- ALUcontrol encodings: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, SLTU 1001.
- immsrc is decoded combinationally from opcode in every state:
  - load and OP-IMM: 00
  - store: 01
  - branch: 10
  - jal: 11
  - other: 00
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, JAL 9, BRANCH 10. Codes 11–15 go to FETCH on the next edge.
- Moore outputs per state. Anything unlisted is 0 / 00 / ADD.
  - FETCH: Adrsrc=0, IRwrite=1, ALUsrcA=00, ALUsrcB=10, Resultsrc=10, PCwrite=1. Next state DECODE.
  - DECODE: ALUsrcA=01, ALUsrcB=01, ADD (precomputes branch/jal target into ALUout). Next state by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100011 with funct3 000 or 001 → BRANCH
    - anything else → FETCH, with illegal=1 this cycle
  - MEMADR: ALUsrcA=10, ALUsrcB=01, ADD. Next state MEMREAD if opcode[5]=0, otherwise MEMWRITE.
  - MEMREAD: Adrsrc=1, Resultsrc=00. Next state MEMWB.
  - MEMWB: Resultsrc=01, Regwrite=1. Next state FETCH.
  - MEMWRITE: Adrsrc=1, Resultsrc=00, Memwrite=1. Next state FETCH.
  - EXECR: ALUsrcA=10, ALUsrcB=00, ALU decode. Next state ALUWB.
  - EXECI: ALUsrcA=10, ALUsrcB=01, ALU decode. Next state ALUWB.
  - ALUWB: Resultsrc=00, Regwrite=1. Next state FETCH.
  - JAL: ALUsrcA=01, ALUsrcB=10, ADD, Resultsrc=00, PCwrite=1. Next state ALUWB.
  - BRANCH: ALUsrcA=10, ALUsrcB=00, SUB, Resultsrc=00, PCwrite=zero1 XOR funct3[0]. Next state FETCH.
- ALU decode by funct3:
  - 000: SUB only if EXECR and funct7[5]=1; otherwise ADD
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRA if funct7[5]=1, else SRL
  - 110: OR
  - 111: AND
  - All other funct7 bits are ignored.
- retire=1 in MEMWB, MEMWRITE, ALUWB and BRANCH. instret increments by 1 on each of those cycles. Illegal instructions do not retire.

## Timing
- Reset: while reset is high, PCwrite, Memwrite, IRwrite, Regwrite, retire and illegal are forced to 0 combinationally. At the edge, state becomes FETCH and instret becomes 0. FETCH strobes start in the first cycle after reset deasserts.
- Reset mid-instruction (any state) aborts the instruction with no partial writeback after the reset edge.
- Cycles per instruction, FETCH through last state:
  - lw 5
  - sw, R-type, OP-IMM, jal 4
  - branch 3
  - illegal 2
- PCwrite in BRANCH depends combinationally on zero1 in the same cycle; no extra latency.
- instret wraps from all-ones to 0 without a flag.

## Test plan
- Reset held 3 cycles in state MEMWB → all strobes 0 during reset; state=0 and instret=0 after; FETCH with IRwrite=PCwrite=1 on the first free cycle.
- lw x1,4(x2) (0x00412083) → state sequence 0,1,2,3,4,0; Regwrite=1 and Resultsrc=01 only in state 4; retire one pulse; instret=1.
- sub x3,x1,x2 (0x402081B3) → EXECR with ALUcontrol=0001; add (0x002081B3) gives 0000; srai (0x4020D193) gives 1000 in EXECI.
- beq with zero1=1 → PCwrite=1 in BRANCH; with zero1=0 → PCwrite=0; bne inverts both cases; 3 cycles; immsrc=10 throughout.
- jal x1,8 (0x008000EF) → states 0,1,9,8,0; immsrc=11; PCwrite in FETCH and JAL; Regwrite in ALUWB.
- Opcode 0x00000037 (lui, unsupported) → illegal pulse in DECODE, back to FETCH; no Regwrite/Memwrite; instret unchanged.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle RV32I control FSM and its datapath.
// The FSM takes the slave view; the datapath (or a bench) takes the master view.
interface multicycle_control_fsm_if #(parameter int CNT_W = 32);
  logic [31:0]      instr;
  logic             zero1;
  logic             PCwrite, Adrsrc, Memwrite, IRwrite, Regwrite;
  logic [1:0]       ALUsrcA, ALUsrcB, Resultsrc, immsrc;
  logic [3:0]       ALUcontrol;
  logic [3:0]       state;
  logic             retire, illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    output instr, zero1,
    input  PCwrite, Adrsrc, Memwrite, IRwrite, Regwrite,
    input  ALUsrcA, ALUsrcB, Resultsrc, immsrc, ALUcontrol,
    input  state, retire, illegal, instret
  );

  modport slave (
    input  instr, zero1,
    output PCwrite, Adrsrc, Memwrite, IRwrite, Regwrite,
    output ALUsrcA, ALUsrcB, Resultsrc, immsrc, ALUcontrol,
    output state, retire, illegal, instret
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main control: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, plus retire pulse, retired-instruction counter and illegal flag.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic reset,
  multicycle_control_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR   = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
                         ALU_SLL  = 4'b0110, ALU_SRL = 4'b0111, ALU_SRA = 4'b1000,
                         ALU_SLTU = 4'b1001;

  state_t st, nxt;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7b;
  logic       pcw, adr, memw, irw, regw, ret, ill;
  logic [1:0] srca, srcb, ress, imms;
  logic [3:0] aluc;
  logic [CNT_W-1:0] cnt;

  assign opc = bus.instr[6:0];
  assign f3  = bus.instr[14:12];
  assign f7b = bus.instr[30];

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  function automatic logic [3:0] alu_dec(input logic [2:0] fn3, input logic f7, input logic is_r);
    case (fn3)
      3'b000:  alu_dec = (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) st <= FETCH;
    else       st <= nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)    cnt <= '0;
    else if (ret) cnt <= cnt + CNT_W'(1);
  end

  always_comb begin
    case (opc)
      7'b0100011: imms = 2'b01;
      7'b1100011: imms = 2'b10;
      7'b1101111: imms = 2'b11;
      default:    imms = 2'b00;
    endcase
  end

  always_comb begin
    nxt  = FETCH;
    pcw  = 1'b0; adr  = 1'b0; memw = 1'b0; irw = 1'b0; regw = 1'b0;
    srca = 2'b00; srcb = 2'b00; ress = 2'b00;
    aluc = ALU_ADD;
    ret  = 1'b0; ill = 1'b0;
    case (st)
      FETCH: begin
        irw = 1'b1; pcw = 1'b1; srcb = 2'b10; ress = 2'b10;
        nxt = DECODE;
      end
      // oldPC + imm lands in ALUout so JAL/BRANCH can use it as the target
      DECODE: begin
        srca = 2'b01; srcb = 2'b01;
        case (opc)
          7'b0000011, 7'b0100011: nxt = MEMADR;
          7'b0110011:             nxt = EXECR;
          7'b0010011:             nxt = EXECI;
          7'b1101111:             nxt = JAL;
          7'b1100011: if (f3[2:1] == 2'b00) nxt = BRANCH;
                      else                  ill = 1'b1;
          default:                ill = 1'b1;
        endcase
      end
      MEMADR: begin
        srca = 2'b10; srcb = 2'b01;
        nxt  = opc[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD:  begin adr = 1'b1; nxt = MEMWB; end
      MEMWB:    begin ress = 2'b01; regw = 1'b1; ret = 1'b1; end
      MEMWRITE: begin adr = 1'b1; memw = 1'b1; ret = 1'b1; end
      EXECR: begin
        srca = 2'b10; aluc = alu_dec(f3, f7b, 1'b1);
        nxt  = ALUWB;
      end
      EXECI: begin
        srca = 2'b10; srcb = 2'b01; aluc = alu_dec(f3, f7b, 1'b0);
        nxt  = ALUWB;
      end
      ALUWB: begin regw = 1'b1; ret = 1'b1; end
      JAL: begin
        srca = 2'b01; srcb = 2'b10; pcw = 1'b1;
        nxt  = ALUWB;
      end
      // funct3[0] distinguishes bne from beq
      BRANCH: begin
        srca = 2'b10; aluc = ALU_SUB; pcw = bus.zero1 ^ f3[0]; ret = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  assign bus.PCwrite    = pcw  & ~reset;
  assign bus.Memwrite   = memw & ~reset;
  assign bus.IRwrite    = irw  & ~reset;
  assign bus.Regwrite   = regw & ~reset;
  assign bus.retire     = ret  & ~reset;
  assign bus.illegal    = ill  & ~reset;
  assign bus.Adrsrc     = adr;
  assign bus.ALUsrcA    = srca;
  assign bus.ALUsrcB    = srcb;
  assign bus.Resultsrc  = ress;
  assign bus.immsrc     = imms;
  assign bus.ALUcontrol = aluc;
  assign bus.state      = st;
  assign bus.instret    = cnt;

endmodule
